// File: rtl/radix_conv_pkg.sv
// rtl/radix_conv_pkg.sv - shared constants and helpers for the radix converters
package radix_conv_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Default RADIX / DIGIT_W pairs
  localparam int RADIX_B3    = 3;
  localparam int DIGIT_W_B3  = 2;
  localparam int RADIX_B10   = 10;
  localparam int DIGIT_W_B10 = 4;

  // Ceiling log2, minimum result 1 so that counters never collapse to zero width
  function automatic int clog2(input int value);
    int res;
    res = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/radix_divmod.sv
// rtl/radix_divmod.sv - combinational unsigned divide/modulo by a constant radix
module radix_divmod #(
  parameter int IN_W    = 16,
  parameter int RADIX   = 3,
  parameter int DIGIT_W = 2
) (
  input  logic [IN_W-1:0]    val,
  output logic [IN_W-1:0]    q,
  output logic [DIGIT_W-1:0] r
);

  localparam logic [IN_W-1:0] RADIX_V = IN_W'(RADIX);

  logic [IN_W-1:0] rem_full;

  // Quotient and remainder; the remainder always fits DIGIT_W because RADIX <= 2**DIGIT_W
  always_comb begin
    q        = val / RADIX_V;
    rem_full = val % RADIX_V;
    r        = DIGIT_W'(rem_full);
  end

endmodule

// File: rtl/base2_to_radix_conv.sv
// rtl/base2_to_radix_conv.sv - iterative binary to base-RADIX digit converter
module base2_to_radix_conv
  import radix_conv_pkg::*;
#(
  parameter int IN_W       = 16,
  parameter int RADIX      = RADIX_B3,
  parameter int DIGIT_W    = DIGIT_W_B3,
  parameter int OUT_DIGITS = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [IN_W-1:0]                     base2_no,
  input  logic                                en,
  output logic                                ready,
  output logic                                busy,
  output logic [OUT_DIGITS*DIGIT_W-1:0]       base_no,
  output logic [clog2(OUT_DIGITS+1)-1:0]      ndigits,
  output logic                                overflow,
  output logic                                done
);

  localparam int                OUT_W    = OUT_DIGITS * DIGIT_W;
  localparam int                CNT_W    = clog2(OUT_DIGITS + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(OUT_DIGITS - 1);

  generate
    if (RADIX < 2 || RADIX > (1 << DIGIT_W) || OUT_DIGITS < 1) begin : g_bad_params
      $error("base2_to_radix_conv: illegal RADIX/DIGIT_W/OUT_DIGITS combination");
    end
  endgenerate

  logic [1:0]        state_q, state_d;
  logic [IN_W-1:0]   val_q;
  logic [CNT_W-1:0]  idx_q;
  logic [OUT_W-1:0]  work_q, work_d;
  logic [OUT_W-1:0]  base_no_q;
  logic [CNT_W-1:0]  ndigits_q;
  logic              overflow_q;
  logic [IN_W-1:0]   q_w;
  logic [DIGIT_W-1:0] r_w;
  logic              div_last;

  radix_divmod #(
    .IN_W    (IN_W),
    .RADIX   (RADIX),
    .DIGIT_W (DIGIT_W)
  ) u_divmod (
    .val (val_q),
    .q   (q_w),
    .r   (r_w)
  );

  assign div_last = (q_w == '0) || (idx_q == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: one DIV cycle per digit, DONE lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en)       state_d = ST_DIV;
      ST_DIV:  if (div_last) state_d = ST_DONE;
      ST_DONE:               state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    ready = (state_q == ST_IDLE);
    busy  = (state_q == ST_DIV) || (state_q == ST_DONE);
    done  = (state_q == ST_DONE);
  end

  // Working register with the current remainder dropped into slot idx
  always_comb begin
    work_d = work_q;
    for (int k = 0; k < OUT_DIGITS; k++) begin
      if (idx_q == CNT_W'(k)) work_d[k*DIGIT_W +: DIGIT_W] = r_w;
    end
  end

  // Datapath; results are loaded on the edge entering DONE so they are valid while done is high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_q      <= '0;
      idx_q      <= '0;
      work_q     <= '0;
      base_no_q  <= '0;
      ndigits_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && en) begin
        val_q  <= base2_no;
        idx_q  <= '0;
        work_q <= '0;
      end
      if (state_q == ST_DIV) begin
        val_q  <= q_w;
        idx_q  <= idx_q + CNT_W'(1);
        work_q <= work_d;
        if (div_last) begin
          base_no_q  <= work_d;
          ndigits_q  <= idx_q + CNT_W'(1);
          overflow_q <= (idx_q == LAST_IDX) && (q_w != '0);
        end
      end
    end
  end

  assign base_no  = base_no_q;
  assign ndigits  = ndigits_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_base2_to_radix_conv.sv
// tb/tb_base2_to_radix_conv.sv - randomized self-checking bench for base2_to_radix_conv
module tb_base2_to_radix_conv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] in_a, in_b, in_c;
  logic        en_a, en_b, en_c;
  logic        ready_a, ready_b, ready_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic [31:0] base_a;
  logic [15:0] base_b;
  logic [63:0] base_c;
  logic [4:0]  nd_a;
  logic [3:0]  nd_b;
  logic [4:0]  nd_c;

  int checks = 0;
  int errors = 0;

  int RAD[3]   = '{3, 3, 10};
  int DW[3]    = '{2, 2, 4};
  int SLOTS[3] = '{16, 8, 16};

  base2_to_radix_conv u_dut_a (
    .clk(clk), .rst_n(rst_n), .base2_no(in_a), .en(en_a), .ready(ready_a), .busy(busy_a),
    .base_no(base_a), .ndigits(nd_a), .overflow(ovf_a), .done(done_a)
  );

  base2_to_radix_conv #(.OUT_DIGITS(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .base2_no(in_b), .en(en_b), .ready(ready_b), .busy(busy_b),
    .base_no(base_b), .ndigits(nd_b), .overflow(ovf_b), .done(done_b)
  );

  base2_to_radix_conv #(.RADIX(10), .DIGIT_W(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .base2_no(in_c), .en(en_c), .ready(ready_c), .busy(busy_c),
    .base_no(base_c), .ndigits(nd_c), .overflow(ovf_c), .done(done_c)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: digit k of v is floor(v / R^k) mod R; digit count is the smallest d with R^d > v
  task automatic model(input int r, input int dw, input int n, input longint v,
                       output logic [63:0] b, output int nd, output bit ov);
    longint p;
    int digits;
    digits = 1;
    p = r;
    while (p <= v) begin
      digits++;
      p = p * r;
    end
    ov = (digits > n);
    nd = ov ? n : digits;
    b = '0;
    p = 1;
    for (int k = 0; k < n; k++) begin
      b = b | (64'((v / p) % r) << (k * dw));
      p = p * r;
    end
  endtask

  function automatic logic [63:0] rd_base(input int sel);
    case (sel)
      0: return 64'(base_a);
      1: return 64'(base_b);
      default: return base_c;
    endcase
  endfunction

  function automatic logic [63:0] rd_nd(input int sel);
    case (sel)
      0: return 64'(nd_a);
      1: return 64'(nd_b);
      default: return 64'(nd_c);
    endcase
  endfunction

  function automatic logic rd_ovf(input int sel);
    case (sel)
      0: return ovf_a;
      1: return ovf_b;
      default: return ovf_c;
    endcase
  endfunction

  function automatic logic rd_done(input int sel);
    case (sel)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic rd_ready(input int sel);
    case (sel)
      0: return ready_a;
      1: return ready_b;
      default: return ready_c;
    endcase
  endfunction

  function automatic logic rd_busy(input int sel);
    case (sel)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic drive(input int sel, input logic [15:0] v, input logic e);
    case (sel)
      0: begin in_a = v; en_a = e; end
      1: begin in_b = v; en_b = e; end
      default: begin in_c = v; en_c = e; end
    endcase
  endtask

  // One full conversion: accept, optionally poke en while busy, wait for done, check everything
  task automatic run_conv(input int sel, input logic [15:0] v, input bit poke, input string tag);
    logic [63:0] eb;
    int          end_nd;
    bit          eo;
    int          cyc;
    model(RAD[sel], DW[sel], SLOTS[sel], longint'(v), eb, end_nd, eo);
    @(negedge clk);
    check({tag, "/ready_before"}, 64'(rd_ready(sel)), 64'd1);
    drive(sel, v, 1'b1);
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    drive(sel, 16'($urandom), poke);
    if (poke) check({tag, "/ready_in_div"}, 64'(rd_ready(sel)), 64'd0);
    while (!rd_done(sel) && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      drive(sel, 16'($urandom), poke && cyc < 4);
    end
    drive(sel, 16'($urandom), 1'b0);
    check({tag, "/done_cycle"}, 64'(cyc), 64'(end_nd + 1));
    check({tag, "/base_no"}, rd_base(sel), eb);
    check({tag, "/ndigits"}, rd_nd(sel), 64'(end_nd));
    check({tag, "/overflow"}, 64'(rd_ovf(sel)), 64'(eo));
    check({tag, "/busy_done"}, 64'(rd_busy(sel)), 64'd1);
    @(negedge clk);
    check({tag, "/done_pulse"}, 64'(rd_done(sel)), 64'd0);
    check({tag, "/base_hold"}, rd_base(sel), eb);
    check({tag, "/ready_after"}, 64'(rd_ready(sel)), 64'd1);
  endtask

  initial begin
    int dones;
    rst_n = 1'b0;
    drive(0, 16'h0, 1'b0);
    drive(1, 16'h0, 1'b0);
    drive(2, 16'h0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/base_no", rd_base(0), 64'd0);
    check("rst/ndigits", rd_nd(0), 64'd0);
    check("rst/overflow", 64'(ovf_a), 64'd0);
    check("rst/done", 64'(done_a), 64'd0);
    check("rst/busy", 64'(busy_a), 64'd0);
    check("rst/ready", 64'(ready_a), 64'd1);
    rst_n = 1'b1;

    // Directed base-3 cases with hand-derived constants
    run_conv(0, 16'd0, 1'b0, "b3_zero");
    check("b3_zero/const", rd_base(0), 64'd0);
    run_conv(0, 16'd5, 1'b0, "b3_five");
    check("b3_five/const", rd_base(0), 64'h0000_0006);
    run_conv(0, 16'hFFFF, 1'b0, "b3_max");
    check("b3_max/const", rd_base(0), 64'h0010_AA08);
    check("b3_max/nd_const", rd_nd(0), 64'd11);
    run_conv(0, 16'd2, 1'b0, "b3_two");
    run_conv(0, 16'd3, 1'b0, "b3_three");

    // Overflow boundary on 8-digit instance
    run_conv(1, 16'd6561, 1'b0, "b3x8_ovf");
    check("b3x8_ovf/const_ovf", 64'(ovf_b), 64'd1);
    check("b3x8_ovf/const_base", rd_base(1), 64'd0);
    run_conv(1, 16'd6560, 1'b0, "b3x8_edge");
    run_conv(1, 16'hFFFF, 1'b0, "b3x8_max");

    // Decimal instance
    run_conv(2, 16'd1234, 1'b0, "b10_1234");
    check("b10_1234/const", rd_base(2) & 64'hFFFF, 64'h1234);
    run_conv(2, 16'd9, 1'b0, "b10_9");
    run_conv(2, 16'd10, 1'b0, "b10_10");
    run_conv(2, 16'hFFFF, 1'b0, "b10_max");

    // Randomized sweeps, en poked while busy on some of them
    for (int i = 0; i < 20; i++) run_conv(0, 16'($urandom), 1'($urandom), "b3_rand");
    for (int i = 0; i < 8; i++) run_conv(1, 16'($urandom_range(0, 8000)), 1'b0, "b3x8_rand");
    for (int i = 0; i < 8; i++) run_conv(2, 16'($urandom), 1'($urandom), "b10_rand");
    run_conv(0, 16'd40000, 1'b1, "b3_poke");

    // Reset in the middle of a conversion discards it
    @(negedge clk);
    drive(0, 16'hFFFF, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 16'h0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst/busy_before", 64'(busy_a), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst/base_no", rd_base(0), 64'd0);
    check("midrst/ndigits", rd_nd(0), 64'd0);
    check("midrst/overflow", 64'(ovf_a), 64'd0);
    check("midrst/ready", 64'(ready_a), 64'd1);
    check("midrst/busy", 64'(busy_a), 64'd0);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    check("midrst/no_done", 64'(dones), 64'd0);
    run_conv(0, 16'd5, 1'b0, "after_rst");
    check("after_rst/const", rd_base(0), 64'h0000_0006);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
